// File: rtl/fetch_if.sv
// Fetch unit bus bundle: instruction-memory request/response, redirect and decoder hand-off.
// master = fetch unit, slave = surrounding memory/decoder environment.
interface fetch_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        fetch_misaligned;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, fetch_misaligned,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, fetch_misaligned,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: keeps at most two words in flight or buffered, tags responses with their pc.
// Optional FETCH_MISALIGN_CHECK_EN halts fetch on a misaligned redirect until an aligned one arrives.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);

  logic [31:0] pc;
  logic [1:0]  outstanding;
  logic [1:0]  drop;
  logic [1:0]  fifo_cnt;
  logic [1:0]  out_next;
  logic [31:0] tag0, tag1;
  logic [31:0] fpc0, fpc1, fdat0, fdat1;
  logic        running;
  logic        accept, rsp, pop, push;

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic {RUN, HALT} state_t;
  state_t state;
  logic   misaligned_q;

  // Misaligned redirect parks the unit; only an aligned redirect restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      misaligned_q <= 1'b0;
    end else if (bus.redirect_valid) begin
      if (bus.redirect_pc[1:0] != 2'b00) begin
        state        <= HALT;
        misaligned_q <= 1'b1;
      end else begin
        state        <= RUN;
        misaligned_q <= 1'b0;
      end
    end
  end

  assign running              = (state == RUN);
  assign bus.fetch_misaligned = misaligned_q;
`else
  logic [1:0] unused_redirect_lsbs;
  assign unused_redirect_lsbs  = bus.redirect_pc[1:0];
  assign running               = 1'b1;
  assign bus.fetch_misaligned  = 1'b0;
`endif

  assign accept = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp    = bus.imem_rsp_valid;
  assign pop    = bus.inst_valid && bus.inst_ready;
  // Responses owed to a stale stream, or landing on a redirect, never reach the FIFO.
  assign push   = rsp && (drop == 2'd0) && !bus.redirect_valid;

  assign bus.imem_req_valid = !rst && running &&
                              (({1'b0, outstanding} + {1'b0, fifo_cnt}) < 3'd2);
  assign bus.imem_req_addr  = pc;
  assign bus.inst_valid     = (fifo_cnt != 2'd0);
  assign bus.inst_pc        = fpc0;
  assign bus.inst_data      = fdat0;

  always_comb begin
    out_next = outstanding;
    if (accept && !rsp)
      out_next = outstanding + 2'd1;
    else if (!accept && rsp)
      out_next = outstanding - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      outstanding <= 2'd0;
      drop        <= 2'd0;
      fifo_cnt    <= 2'd0;
      tag0        <= 32'd0;
      tag1        <= 32'd0;
      fpc0        <= 32'd0;
      fpc1        <= 32'd0;
      fdat0       <= 32'd0;
      fdat1       <= 32'd0;
    end else begin
      outstanding <= out_next;

      // Tag queue mirrors the in-flight requests, so responses pick up their pc in order.
      case ({accept, rsp})
        2'b10: begin
          if (outstanding == 2'd0) tag0 <= pc;
          else                     tag1 <= pc;
        end
        2'b01: tag0 <= tag1;
        2'b11: begin
          if (outstanding == 2'd1) begin
            tag0 <= pc;
          end else begin
            tag0 <= tag1;
            tag1 <= pc;
          end
        end
        default: ;
      endcase

      if (bus.redirect_valid) begin
        pc       <= {bus.redirect_pc[31:2], 2'b00};
        drop     <= out_next;
        fifo_cnt <= 2'd0;
      end else begin
        if (accept)
          pc <= pc + 32'd4;
        if (rsp && (drop != 2'd0))
          drop <= drop - 2'd1;

        case ({push, pop})
          2'b10: begin
            if (fifo_cnt == 2'd0) begin
              fpc0  <= tag0;
              fdat0 <= bus.imem_rsp_data;
            end else begin
              fpc1  <= tag0;
              fdat1 <= bus.imem_rsp_data;
            end
            fifo_cnt <= fifo_cnt + 2'd1;
          end
          2'b01: begin
            fpc0     <= fpc1;
            fdat0    <= fdat1;
            fifo_cnt <= fifo_cnt - 2'd1;
          end
          2'b11: begin
            if (fifo_cnt == 2'd1) begin
              fpc0  <= tag0;
              fdat0 <= bus.imem_rsp_data;
            end else begin
              fpc0  <= fpc1;
              fdat0 <= fdat1;
              fpc1  <= tag0;
              fdat1 <= bus.imem_rsp_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
